// File: rtl/operand_fetch_stage_pkg.sv
// Shared sizing for the operand fetch stage and its register scoreboard.
// Widths must agree with the register file this stage reads from.
package operand_fetch_stage_pkg;

    localparam int BITSIZE_DEF = 16;
    localparam int ADDSIZE_DEF = 4;
    localparam int OPSIZE_DEF  = 6;
    localparam int NREGS_DEF   = 2 ** ADDSIZE_DEF;

    function automatic int num_regs(input int addsize);
        return 2 ** addsize;
    endfunction

endpackage

// File: rtl/operand_fetch_stage_scoreboard.sv
// One pending bit per architectural register, set on issue of a writer and
// cleared on writeback; a same-cycle set of the same register wins.
module reg_scoreboard
    import operand_fetch_stage_pkg::*;
#(
    parameter int ADDSIZE = ADDSIZE_DEF,
    parameter int NREGS   = num_regs(ADDSIZE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_set,
    input  logic [ADDSIZE-1:0] i_set_rw,
    input  logic               i_clr,
    input  logic [ADDSIZE-1:0] i_clr_rw,
    output logic [NREGS-1:0]   o_pending
);

    logic [NREGS-1:0] r_pending;
    logic [NREGS-1:0] w_pending_nxt;

    // Clear first, then set: the newly issued write is younger than the writeback.
    always_comb begin
        w_pending_nxt = r_pending;
        if (i_clr) begin
            w_pending_nxt[i_clr_rw] = 1'b0;
        end
        if (i_set) begin
            w_pending_nxt[i_set_rw] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: drives regfile read addresses, resolves RAW/WAW hazards against
// the scoreboard, bypasses same-cycle writeback, and registers operands for execute.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int BITSIZE = BITSIZE_DEF,
    parameter int ADDSIZE = ADDSIZE_DEF,
    parameter int OPSIZE  = OPSIZE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDSIZE-1:0] in_ra,
    input  logic [ADDSIZE-1:0] in_rb,
    input  logic [ADDSIZE-1:0] in_rw,
    input  logic               in_wr,
    input  logic [OPSIZE-1:0]  in_op,
    output logic [ADDSIZE-1:0] rf_ra,
    output logic [ADDSIZE-1:0] rf_rb,
    input  logic [BITSIZE-1:0] rf_adat,
    input  logic [BITSIZE-1:0] rf_bdat,
    input  logic               wb_valid,
    input  logic [ADDSIZE-1:0] wb_rw,
    input  logic [BITSIZE-1:0] wb_wdat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BITSIZE-1:0] out_a,
    output logic [BITSIZE-1:0] out_b,
    output logic [ADDSIZE-1:0] out_rw,
    output logic               out_wr,
    output logic [OPSIZE-1:0]  out_op
);

    localparam int NREGS = num_regs(ADDSIZE);

    function automatic logic [BITSIZE-1:0] sel_operand(
        input logic               hit,
        input logic [BITSIZE-1:0] wdat,
        input logic [BITSIZE-1:0] rdat
    );
        return hit ? wdat : rdat;
    endfunction

    logic [NREGS-1:0]   w_pending;
    logic               w_hit_a;
    logic               w_hit_b;
    logic               w_hit_w;
    logic               w_stall_a;
    logic               w_stall_b;
    logic               w_stall_w;
    logic               w_out_free;
    logic               w_accept;
    logic [BITSIZE-1:0] w_opnd_a;
    logic [BITSIZE-1:0] w_opnd_b;

    logic               r_vld_p1;
    logic [BITSIZE-1:0] r_a_p1;
    logic [BITSIZE-1:0] r_b_p1;
    logic [ADDSIZE-1:0] r_rw_p1;
    logic               r_wr_p1;
    logic [OPSIZE-1:0]  r_op_p1;

    assign rf_ra = in_ra;
    assign rf_rb = in_rb;

    // A writeback landing this cycle satisfies the hazard it would otherwise cause.
    assign w_hit_a   = wb_valid && (wb_rw == in_ra);
    assign w_hit_b   = wb_valid && (wb_rw == in_rb);
    assign w_hit_w   = wb_valid && (wb_rw == in_rw);
    assign w_stall_a = w_pending[in_ra] && !w_hit_a;
    assign w_stall_b = w_pending[in_rb] && !w_hit_b;
    assign w_stall_w = in_wr && w_pending[in_rw] && !w_hit_w;

    assign w_out_free = !r_vld_p1 || out_ready;
    assign in_ready   = !rst && !w_stall_a && !w_stall_b && !w_stall_w && w_out_free;
    assign w_accept   = in_valid && in_ready;

    assign w_opnd_a = sel_operand(w_hit_a, wb_wdat, rf_adat);
    assign w_opnd_b = sel_operand(w_hit_b, wb_wdat, rf_bdat);

    reg_scoreboard #(
        .ADDSIZE (ADDSIZE),
        .NREGS   (NREGS)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .i_set     (w_accept && in_wr),
        .i_set_rw  (in_rw),
        .i_clr     (wb_valid),
        .i_clr_rw  (wb_rw),
        .o_pending (w_pending)
    );

    // ---- p1: operands handed to execute ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_a_p1   <= '0;
            r_b_p1   <= '0;
            r_rw_p1  <= '0;
            r_wr_p1  <= 1'b0;
            r_op_p1  <= '0;
        end else if (w_accept) begin
            r_vld_p1 <= 1'b1;
            r_a_p1   <= w_opnd_a;
            r_b_p1   <= w_opnd_b;
            r_rw_p1  <= in_rw;
            r_wr_p1  <= in_wr;
            r_op_p1  <= in_op;
        end else if (out_ready) begin
            r_vld_p1 <= 1'b0;
        end
    end

    assign out_valid = r_vld_p1;
    assign out_a     = r_a_p1;
    assign out_b     = r_b_p1;
    assign out_rw    = r_rw_p1;
    assign out_wr    = r_wr_p1;
    assign out_op    = r_op_p1;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scenario bench for operand_fetch_stage with an in-order expected-result queue.
module tb_operand_fetch_stage;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  rw;
        logic        wr;
        logic [5:0]  op;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_ra, in_rb, in_rw;
    logic        in_wr;
    logic [5:0]  in_op;
    logic [3:0]  rf_ra, rf_rb;
    logic [15:0] rf_adat, rf_bdat;
    logic        wb_valid;
    logic [3:0]  wb_rw;
    logic [15:0] wb_wdat;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_a, out_b;
    logic [3:0]  out_rw;
    logic        out_wr;
    logic [5:0]  out_op;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   xfer_cnt = 0;
    logic last_ready;

    always #5 clk = ~clk;

    operand_fetch_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ra(in_ra), .in_rb(in_rb), .in_rw(in_rw), .in_wr(in_wr), .in_op(in_op),
        .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_adat(rf_adat), .rf_bdat(rf_bdat),
        .wb_valid(wb_valid), .wb_rw(wb_rw), .wb_wdat(wb_wdat),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_rw(out_rw), .out_wr(out_wr), .out_op(out_op)
    );

    // Samples handshakes at the falling edge, then returns just after the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_ready = in_ready;
        if (in_valid && in_ready) begin
            e.a  = (wb_valid && wb_rw == in_ra) ? wb_wdat : rf_adat;
            e.b  = (wb_valid && wb_rw == in_rb) ? wb_wdat : rf_bdat;
            e.rw = in_rw;
            e.wr = in_wr;
            e.op = in_op;
            q.push_back(e);
        end
        if (out_valid && out_ready) begin
            xfer_cnt++;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL xfer_unexpected got op=%h a=%h required no transfer", out_op, out_a);
            end else begin
                e = q.pop_front();
                if ({out_a, out_b, out_rw, out_wr, out_op} !== e) begin
                    bad++;
                    $display("FAIL xfer_data got a=%h b=%h rw=%h wr=%b op=%h required a=%h b=%h rw=%h wr=%b op=%h",
                             out_a, out_b, out_rw, out_wr, out_op, e.a, e.b, e.rw, e.wr, e.op);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rw,
                          input logic wr, input logic [5:0] op,
                          input logic [15:0] ad, input logic [15:0] bd);
        in_valid = 1'b1;
        in_ra = ra; in_rb = rb; in_rw = rw; in_wr = wr; in_op = op;
        rf_adat = ad; rf_bdat = bd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(4'd1, 4'd2, 4'd0, 1'b0, 6'h3F, 16'h1234, 16'h5678);
        tick();
        total++;
        if (last_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b required=0", last_ready); end
        total++;
        if ({out_valid, out_a, out_b, out_rw, out_wr, out_op} !== 44'h0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b a=%h b=%h rw=%h wr=%b op=%h required all 0",
                     out_valid, out_a, out_b, out_rw, out_wr, out_op);
        end
        total++;
        if (dut.w_pending !== 16'h0) begin bad++; $display("FAIL reset_pending got=%h required=0000", dut.w_pending); end
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        set_in(4'd1, 4'd2, 4'd0, 1'b0, 6'h01, 16'h1111, 16'h2222);
        tick();
        total++;
        if (last_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b required=1", last_ready); end
        total++;
        if ({out_valid, out_a, out_b} !== {1'b1, 16'h1111, 16'h2222}) begin
            bad++;
            $display("FAIL basic_out got v=%b a=%h b=%h required v=1 a=1111 b=2222", out_valid, out_a, out_b);
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (dut.w_pending !== 16'h0) begin bad++; $display("FAIL basic_pending got=%h required=0000", dut.w_pending); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b required=0", out_valid); end
    endtask

    task automatic test_bypass();
        set_in(4'd0, 4'd0, 4'd3, 1'b1, 6'h02, 16'h0000, 16'h0000);
        tick();
        total++;
        if (dut.w_pending[3] !== 1'b1) begin bad++; $display("FAIL bypass_set got=%b required=1", dut.w_pending[3]); end
        set_in(4'd3, 4'd4, 4'd0, 1'b0, 6'h03, 16'hDEAD, 16'h4444);
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if (last_ready !== 1'b0) begin bad++; $display("FAIL bypass_stall[%0d] got=%b required=0", k, last_ready); end
        end
        wb_valid = 1'b1; wb_rw = 4'd3; wb_wdat = 16'hBEEF;
        tick();
        total++;
        if (last_ready !== 1'b1) begin bad++; $display("FAIL bypass_accept got=%b required=1", last_ready); end
        total++;
        if ({out_a, out_b} !== {16'hBEEF, 16'h4444}) begin
            bad++;
            $display("FAIL bypass_data got a=%h b=%h required a=BEEF b=4444", out_a, out_b);
        end
        wb_valid = 1'b0;
        in_valid = 1'b0;
        tick();
        total++;
        if (dut.w_pending[3] !== 1'b0) begin bad++; $display("FAIL bypass_clear got=%b required=0", dut.w_pending[3]); end
    endtask

    task automatic test_waw();
        set_in(4'd6, 4'd7, 4'd5, 1'b1, 6'h04, 16'h0606, 16'h0707);
        tick();
        total++;
        if (last_ready !== 1'b1) begin bad++; $display("FAIL waw_first got=%b required=1", last_ready); end
        set_in(4'd6, 4'd7, 4'd5, 1'b1, 6'h05, 16'h0616, 16'h0717);
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if (last_ready !== 1'b0) begin bad++; $display("FAIL waw_hold[%0d] got=%b required=0", k, last_ready); end
        end
        wb_valid = 1'b1; wb_rw = 4'd5; wb_wdat = 16'h5555;
        tick();
        total++;
        if (last_ready !== 1'b1) begin bad++; $display("FAIL waw_release got=%b required=1", last_ready); end
        wb_valid = 1'b0;
        in_valid = 1'b0;
        tick();
        total++;
        if (dut.w_pending !== 16'h0020) begin bad++; $display("FAIL waw_set_wins got=%h required=0020", dut.w_pending); end
        wb_valid = 1'b1; wb_rw = 4'd5; wb_wdat = 16'h5556;
        tick();
        wb_valid = 1'b0;
        total++;
        if (dut.w_pending !== 16'h0) begin bad++; $display("FAIL waw_clear got=%h required=0000", dut.w_pending); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_in(4'd1, 4'd2, 4'd0, 1'b0, 6'h11, 16'h3333, 16'h4444);
        tick();
        total++;
        if (last_ready !== 1'b1) begin bad++; $display("FAIL bp_first got=%b required=1", last_ready); end
        set_in(4'd8, 4'd9, 4'd0, 1'b0, 6'h12, 16'h5555, 16'h6666);
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (last_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b required=0", k, last_ready); end
            total++;
            if ({out_valid, out_a, out_b, out_op} !== {1'b1, 16'h3333, 16'h4444, 6'h11}) begin
                bad++;
                $display("FAIL bp_hold[%0d] got v=%b a=%h b=%h op=%h required v=1 a=3333 b=4444 op=11",
                         k, out_valid, out_a, out_b, out_op);
            end
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (last_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b required=1", last_ready); end
        total++;
        if ({out_valid, out_op} !== {1'b1, 6'h12}) begin
            bad++;
            $display("FAIL bp_next got v=%b op=%h required v=1 op=12", out_valid, out_op);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_rst_midflight();
        out_ready = 1'b1;
        set_in(4'd0, 4'd0, 4'd1, 1'b1, 6'h21, 16'h0101, 16'h0202);
        tick();
        set_in(4'd0, 4'd0, 4'd2, 1'b1, 6'h22, 16'h0303, 16'h0404);
        tick();
        total++;
        if (dut.w_pending !== 16'h0006) begin bad++; $display("FAIL rst_pre_pending got=%h required=0006", dut.w_pending); end
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b required=0", out_valid); end
        total++;
        if (dut.w_pending !== 16'h0) begin bad++; $display("FAIL rst_mid_pending got=%h required=0000", dut.w_pending); end
        out_ready = 1'b1;
        set_in(4'd1, 4'd2, 4'd0, 1'b0, 6'h23, 16'hAAAA, 16'hBBBB);
        tick();
        total++;
        if (last_ready !== 1'b1) begin bad++; $display("FAIL rst_read_r1 got=%b required=1", last_ready); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int start;
        out_ready = 1'b1;
        start = xfer_cnt;
        for (int i = 0; i < 8; i++) begin
            set_in(4'(i), 4'(i + 8), 4'd0, 1'b0, 6'(6'h30 + i), 16'(16'h1000 + i), 16'(16'h2000 + i));
            tick();
            total++;
            if ({last_ready, out_valid} !== 2'b11) begin
                bad++;
                $display("FAIL stream[%0d] got ready=%b out_valid=%b required 1 1", i, last_ready, out_valid);
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (xfer_cnt - start !== 8) begin bad++; $display("FAIL stream_count got=%0d required=8", xfer_cnt - start); end
        total++;
        if (q.size() !== 0) begin bad++; $display("FAIL stream_leftover got=%0d required=0", q.size()); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_ra = '0; in_rb = '0; in_rw = '0; in_wr = 1'b0; in_op = '0;
        rf_adat = '0; rf_bdat = '0;
        wb_valid = 1'b0; wb_rw = '0; wb_wdat = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_bypass();
        test_waw();
        test_backpressure();
        test_rst_midflight();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
